// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and types for the parametrised interrupt controller.
//   - register addresses on the 3-bit register port
//   - bit positions inside the CTRL and EOI registers
//   - pic_state_t: request FSM states
package pic_pkg;

    localparam logic [2:0] ADDR_IMR  = 3'd0;
    localparam logic [2:0] ADDR_TRIG = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_EOI  = 3'd3;
    localparam logic [2:0] ADDR_IRR  = 3'd4;
    localparam logic [2:0] ADDR_ISR  = 3'd5;

    localparam int CTRL_ROTATE_BIT  = 0;
    localparam int CTRL_AEOI_BIT    = 1;
    localparam int CTRL_BASE_LSB    = 8;
    localparam int EOI_SPECIFIC_BIT = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pic_state_t;

endpackage

// File: rtl/pic_rot_prio.sv
// pic_rot_prio: rotated find-first. Scans req starting at channel ptr and
// wrapping modulo NUM_IRQ; the first set bit met is the highest priority.
//   req   in  NUM_IRQ : request vector
//   ptr   in  IDX_W   : highest-priority channel
//   found out 1       : any bit of req set
//   idx   out IDX_W   : channel index of the winner (0 when none)
module pic_rot_prio #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int c;
        logic [IDX_W-1:0] sel;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        sel   = '0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= NUM_IRQ) c = c - NUM_IRQ;
            sel = IDX_W'(c);
            if (req[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
    end

endmodule

// File: rtl/pic_param_controller.sv
// pic_param_controller: clocked 8259-style interrupt controller.
//   clk, reset          : clock, synchronous active-high reset
//   irq[NUM_IRQ]        : request lines (already synchronous)
//   reg_wr/reg_rd       : register write / read strobes
//   reg_addr, reg_wdata : register select and write data
//   reg_rdata           : read data, registered one cycle after reg_rd
//   int_o               : interrupt request to the CPU
//   int_ack             : one-cycle acknowledge from the CPU
//   vector, vec_valid   : acknowledge response and its one-cycle strobe
module pic_param_controller #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [2:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               int_o,
    input  logic               int_ack,
    output logic [VEC_W-1:0]   vector,
    output logic               vec_valid
);
    import pic_pkg::*;

    logic [NUM_IRQ-1:0] imr, trig, irr, isr, irq_q, isr_post;
    logic               rotate, aeoi;
    logic [VEC_W-1:0]   base;
    logic [IDX_W-1:0]   ptr, cand_idx, isr_idx, eoi_ch, spec_ch;
    logic               cand_found, isr_found, eoi_hit;
    logic               elig_reg, elig_ack, ack_hit;
    logic [31:0]        rd_mux;
    pic_state_t         state, state_nxt;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;

    // Distance of channel c below the top-priority pointer p (0 = highest).
    function automatic int rank_of(input logic [IDX_W-1:0] c, input logic [IDX_W-1:0] p);
        int ci, pi;
        ci = int'(c);
        pi = int'(p);
        return (ci >= pi) ? (ci - pi) : (ci + NUM_IRQ - pi);
    endfunction

    // True when channel c strictly outranks every in-service channel.
    function automatic logic outranks_all(input logic [NUM_IRQ-1:0] srv,
                                          input logic [IDX_W-1:0] c,
                                          input logic [IDX_W-1:0] p);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < NUM_IRQ; j++)
            if (srv[j] && rank_of(IDX_W'(j), p) <= rank_of(c, p)) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] c);
        return NUM_IRQ'(1) << c;
    endfunction

    function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] c);
        return (c == IDX_W'(NUM_IRQ - 1)) ? '0 : c + IDX_W'(1);
    endfunction

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    pic_rot_prio #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_irr_prio (
        .req   (irr & ~imr),
        .ptr   (ptr),
        .found (cand_found),
        .idx   (cand_idx)
    );

    pic_rot_prio #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_prio (
        .req   (isr),
        .ptr   (ptr),
        .found (isr_found),
        .idx   (isr_idx)
    );

    // EOI decode; the cleared channel feeds both ISR and the rotation pointer.
    assign spec_ch = reg_wdata[IDX_W-1:0];
    always_comb begin
        eoi_hit = 1'b0;
        eoi_ch  = '0;
        if (reg_wr && reg_addr == ADDR_EOI) begin
            if (reg_wdata[EOI_SPECIFIC_BIT]) begin
                if (int'(spec_ch) < NUM_IRQ && isr[spec_ch]) begin
                    eoi_hit = 1'b1;
                    eoi_ch  = spec_ch;
                end
            end else if (isr_found) begin
                eoi_hit = 1'b1;
                eoi_ch  = isr_idx;
            end
        end
    end

    assign isr_post = eoi_hit ? (isr & ~onehot(eoi_ch)) : isr;

    // The FSM follows registered state; an acknowledge sees a same-cycle EOI.
    assign elig_reg = cand_found && outranks_all(isr, cand_idx, ptr);
    assign elig_ack = cand_found && outranks_all(isr_post, cand_idx, ptr);
    assign ack_hit  = int_ack && (state == ST_PEND) && elig_ack;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (elig_reg) state_nxt = ST_PEND;
            ST_PEND: if (int_ack || !elig_reg) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        int_o = (state == ST_PEND);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_IMR:  rd_mux = zext(imr);
            ADDR_TRIG: rd_mux = zext(trig);
            ADDR_CTRL: begin
                rd_mux[CTRL_ROTATE_BIT]            = rotate;
                rd_mux[CTRL_AEOI_BIT]              = aeoi;
                rd_mux[CTRL_BASE_LSB +: VEC_W]     = base;
            end
            ADDR_IRR:  rd_mux = zext(irr);
            ADDR_ISR:  rd_mux = zext(isr);
            default:   rd_mux = '0;
        endcase
    end

    // Register stage: request capture, service state, configuration, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            imr       <= '1;
            trig      <= '0;
            rotate    <= 1'b0;
            aeoi      <= 1'b0;
            base      <= '0;
            irr       <= '0;
            isr       <= '0;
            ptr       <= '0;
            vector    <= '0;
            vec_valid <= 1'b0;
            reg_rdata <= '0;
        end else begin
            irq_q <= irq;
            if (reg_wr) begin
                case (reg_addr)
                    ADDR_IMR:  imr  <= reg_wdata[NUM_IRQ-1:0];
                    ADDR_TRIG: trig <= reg_wdata[NUM_IRQ-1:0];
                    ADDR_CTRL: begin
                        rotate <= reg_wdata[CTRL_ROTATE_BIT];
                        aeoi   <= reg_wdata[CTRL_AEOI_BIT];
                        base   <= reg_wdata[CTRL_BASE_LSB +: VEC_W];
                    end
                    default: ;
                endcase
            end
            // New edge is OR-ed after the acknowledge clear, so a set wins.
            irr <= (trig & irq)
                 | (~trig & ((irr & ~(ack_hit ? onehot(cand_idx) : '0)) | (irq & ~irq_q)));
            isr <= isr_post | ((ack_hit && !aeoi) ? onehot(cand_idx) : '0);
            if (ack_hit && aeoi && rotate)
                ptr <= next_ch(cand_idx);
            else if (eoi_hit && rotate)
                ptr <= next_ch(eoi_ch);
            vec_valid <= int_ack;
            if (int_ack)
                vector <= ack_hit ? (base + VEC_W'(cand_idx)) : (base + VEC_W'(NUM_IRQ - 1));
            if (reg_rd)
                reg_rdata <= rd_mux;
        end
    end

endmodule
